// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops words from a show-ahead FIFO and packs RATIO of them into one valid/ready beat.
// A flush request emits the partial beat that has been collected so far, with a word-keep mask.
module fifo_rd_packer #(
  parameter int DWIDTH = 32,
  parameter int RATIO  = 4
) (
  input  logic                     rclk,
  input  logic                     rrstn,
  input  logic                     fifo_rempty,
  input  logic [DWIDTH-1:0]        fifo_rdata,
  output logic                     fifo_rden,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DWIDTH*RATIO-1:0]  m_data,
  output logic [RATIO-1:0]         m_keep,
  output logic                     m_last
);
  localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam logic [0:0] S_ACC   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]              r_state;
  logic [IW-1:0]           r_idx;
  logic                    r_flush_pend;
  logic [DWIDTH-1:0]       r_acc [RATIO];
  logic                    w_slot_free;
  logic                    w_fill;
  logic                    w_emit;
  logic [DWIDTH*RATIO-1:0] w_full;
  logic [DWIDTH*RATIO-1:0] w_part;
  logic [RATIO-1:0]        w_part_keep;

  assign w_slot_free = ~m_valid | m_ready;
  assign w_fill      = r_idx == IW'(RATIO - 1);
  // The m_ready -> fifo_rden path is combinational so a full beat can pop every cycle.
  assign fifo_rden   = rrstn & ~fifo_rempty & (r_state == S_ACC) & ~r_flush_pend & (~w_fill | w_slot_free);
  assign w_emit      = (r_state == S_FLUSH) & (r_idx != '0) & w_slot_free;

  // The top word of a full beat comes straight from the FIFO head; stale words are masked on flush.
  always_comb begin
    w_full      = '0;
    w_part      = '0;
    w_part_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_full[i*DWIDTH +: DWIDTH] = (i == RATIO - 1) ? fifo_rdata : r_acc[i];
      w_part_keep[i]             = IW'(i) < r_idx;
      w_part[i*DWIDTH +: DWIDTH] = w_part_keep[i] ? r_acc[i] : '0;
    end
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      r_state      <= S_ACC;
      r_idx        <= '0;
      r_flush_pend <= 1'b0;
      r_acc        <= '{default: '0};
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_keep       <= '0;
      m_last       <= 1'b0;
    end else begin
      if (fifo_rden) begin
        r_acc[r_idx] <= fifo_rdata;
        r_idx        <= w_fill ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_ACC) begin
        if (flush) begin
          r_state      <= S_FLUSH;
          r_flush_pend <= 1'b1;
        end
      end else if (r_idx == '0 || w_slot_free) begin
        r_state      <= S_ACC;
        r_flush_pend <= 1'b0;
        r_idx        <= '0;
      end
      if (fifo_rden && w_fill) begin
        m_valid <= 1'b1;
        m_data  <= w_full;
        m_keep  <= '1;
        m_last  <= 1'b0;
      end else if (w_emit) begin
        m_valid <= 1'b1;
        m_data  <= w_part;
        m_keep  <= w_part_keep;
        m_last  <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule
